// File: rtl/oclib_async_req_ack_mux_to_ready_valid_pkg.sv
// Shared definitions for the 4-phase req/ack block family: the handshake
// FSM state type and a helper for sizing channel-index fields.
package oclib_pkg;

  // Receiver side of a 4-phase handshake: waiting for a request, or holding ack.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } req_ack_state_e;

  // Width of a channel index; a single channel still gets a 1-bit field.
  function automatic int chan_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oclib_async_req_ack_mux_to_ready_valid_if.sv
// Bundle of the async req/ack inputs and the merged ready/valid output.
//
// Output handshake: a beat transfers on a clock edge where outValid && outReady.
// Once outValid is high, outData/outChannel hold and outValid stays high until
// that transfer; outReady may change freely and never depends on outValid.
// Input side: per channel, 4-phase req/ack; data is stable while inReq[c] is high.
interface oclib_async_req_ack_mux_to_ready_valid_if #(
  parameter int Width    = 8,
  parameter int Channels = 4
);
  localparam int ChanBits = oclib_pkg::chan_bits(Channels);

  logic [Channels*Width-1:0] inData;
  logic [Channels-1:0]       inReq;
  logic [Channels-1:0]       inAck;
  logic [Width-1:0]          outData;
  logic [ChanBits-1:0]       outChannel;
  logic                      outValid;
  logic                      outReady;
  logic [31:0]               statTransfers;

  // The block itself: receives requests, produces the merged stream.
  modport master (
    input  inData, inReq, outReady,
    output inAck, outData, outChannel, outValid, statTransfers
  );

  // The environment: async senders plus the downstream consumer.
  modport slave (
    output inData, inReq, outReady,
    input  inAck, outData, outChannel, outValid, statTransfers
  );
endinterface

// File: rtl/oclib_async_req_ack_mux_to_ready_valid_chan.sv
// One receive channel: synchronizer on {req,data}, 4-phase handshake FSM and
// a Depth-entry FIFO. A beat is captured only from IDLE when the FIFO had room
// at the start of the cycle; a pop in the same cycle does not create room.
module oclib_async_req_ack_chan
  import oclib_pkg::*;
#(
  parameter int Width      = 8,
  parameter int Depth      = 4,
  parameter int SyncCycles = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req_i,
  input  logic [Width-1:0] data_i,
  output req_ack_state_e state_o,
  input  logic           pop_i,
  output logic [Width-1:0] data_o,
  output logic           empty_o
);
  localparam int AddrBits = $clog2(Depth);

  logic [Width:0]      sync_q [SyncCycles];
  logic                req_sync;
  logic [Width-1:0]    data_sync;
  req_ack_state_e      state_q, state_d;
  logic                wr_en;
  logic                full;
  logic [AddrBits:0]   wr_q, rd_q;
  logic [Width-1:0]    mem_q [Depth];

  assign {req_sync, data_sync} = sync_q[SyncCycles-1];
  assign state_o = state_q;

  // Shift {req,data} through SyncCycles flops; data is stable while req is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SyncCycles; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {req_i, data_i};
      for (int i = 1; i < SyncCycles; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Handshake state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture from IDLE when room exists; release ack once the request drops.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: if (req_sync && !full) begin
        wr_en   = 1'b1;
        state_d = ACK;
      end
      ACK: if (!req_sync) state_d = IDLE;
    endcase
  end

  // Pointers carry a wrap bit: equal means empty, MSB-only difference means full.
  assign empty_o = (wr_q == rd_q);
  assign full    = (wr_q[AddrBits] != rd_q[AddrBits]) &&
                   (wr_q[AddrBits-1:0] == rd_q[AddrBits-1:0]);
  assign data_o  = mem_q[rd_q[AddrBits-1:0]];

  // Advance write/read pointers; both may move in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en)            wr_q <= wr_q + {{AddrBits{1'b0}}, 1'b1};
      if (pop_i && !empty_o) rd_q <= rd_q + {{AddrBits{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: nothing is read until a pointer marks it valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_q[AddrBits-1:0]] <= data_sync;
  end

endmodule

// File: rtl/oclib_async_req_ack_mux_to_ready_valid.sv
// Merges Channels async 4-phase req/ack sources onto one registered
// ready/valid stream tagged with the source channel, round-robin arbitrated.
// Optional transfer counter: define OC_ASYNC_REQ_ACK_MUX_STATS_EN.
module oclib_async_req_ack_mux_to_ready_valid
  import oclib_pkg::*;
#(
  parameter int Width      = 8,
  parameter int Channels   = 4,
  parameter int Depth      = 4,
  parameter int SyncCycles = 3
) (
  input logic clock,
  input logic reset,
  oclib_async_req_ack_mux_to_ready_valid_if.master bus
);
  localparam int ChanBits = chan_bits(Channels);

  logic [Channels-1:0] chan_empty;
  logic [Channels-1:0] chan_pop;
  logic [Channels-1:0] chan_ack;
  logic [Width-1:0]    chan_data  [Channels];
  req_ack_state_e      chan_state [Channels];
  logic [ChanBits-1:0] scan_idx   [Channels];

  logic [ChanBits-1:0] rr_q;
  logic [ChanBits-1:0] grant_idx;
  logic [ChanBits-1:0] next_rr;
  logic                grant_vld;
  logic                out_load;
  logic                out_valid_q;
  logic [Width-1:0]    out_data_q;
  logic [ChanBits-1:0] out_chan_q;

  for (genvar c = 0; c < Channels; c++) begin : g_chan
    oclib_async_req_ack_chan #(
      .Width      (Width),
      .Depth      (Depth),
      .SyncCycles (SyncCycles)
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .req_i   (bus.inReq[c]),
      .data_i  (bus.inData[c*Width +: Width]),
      .state_o (chan_state[c]),
      .pop_i   (chan_pop[c]),
      .data_o  (chan_data[c]),
      .empty_o (chan_empty[c])
    );
    assign chan_ack[c] = (chan_state[c] == ACK);
    // Candidate order for this cycle: rr_q, rr_q+1, ... wrapping at Channels.
    assign scan_idx[c] = ChanBits'((32'(rr_q) + 32'(c)) % 32'(Channels));
  end

  assign bus.inAck = chan_ack;

  // First non-empty channel in scan order wins (reverse loop keeps the earliest).
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = Channels - 1; i >= 0; i--) begin
      if (!chan_empty[scan_idx[i]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[i];
      end
    end
  end

  assign out_load = !out_valid_q || bus.outReady;
  assign next_rr  = ChanBits'((32'(grant_idx) + 32'd1) % 32'(Channels));

  // Pop the granted FIFO only when the output register is taking its head.
  always_comb begin
    chan_pop = '0;
    if (out_load && grant_vld) chan_pop[grant_idx] = 1'b1;
  end

  // Output register: refill from the grant, or go idle when nothing is queued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_q        <= '0;
    end else if (out_load) begin
      out_valid_q <= grant_vld;
      if (grant_vld) begin
        out_data_q <= chan_data[grant_idx];
        out_chan_q <= grant_idx;
        rr_q       <= next_rr;
      end
    end
  end

  assign bus.outValid   = out_valid_q;
  assign bus.outData    = out_data_q;
  assign bus.outChannel = out_chan_q;

`ifdef OC_ASYNC_REQ_ACK_MUX_STATS_EN
  logic [31:0] stat_q;

  // Count accepted output beats; wraps naturally at 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          stat_q <= '0;
    else if (out_valid_q && bus.outReady) stat_q <= stat_q + 32'd1;
  end

  assign bus.statTransfers = stat_q;
`else
  assign bus.statTransfers = 32'd0;
`endif

endmodule

// File: doc/oclib_async_req_ack_mux_to_ready_valid.md
Name: oclib_async_req_ack_mux_to_ready_valid

Overview:
Multi-channel successor to the single-channel async req/ack receiver. Channels independent 4-phase req/ack inputs from foreign clock domains are synchronized and captured into per-channel FIFOs, so a channel is acked while the output is busy. The channels are then round-robin merged onto one registered ready/valid output tagged with the source channel. It sits at clock-domain boundaries that collect several slow async command/status sources into one local stream.

Parameters:
Width, 8, data bits per channel
Channels, 4, number of async req/ack inputs (1..16)
Depth, 4, per-channel FIFO entries (power of 2, >=2)
SyncCycles, 3, synchronizer flops on {req,data} (>=2)
ChanBits, $clog2(Channels) min 1, derived localparam, width of outChannel

Ports:
clock  input  1  sole clock
reset  input  1  asynchronous, active-low; assertion clears all state immediately; deassertion is synchronous to clock upstream
inData  input  Channels*Width  per-channel data, channel c at [c*Width +: Width], held stable by sender while inReq[c]=1
inReq  input  Channels  per-channel 4-phase request, asynchronous
inAck  output  Channels  per-channel 4-phase acknowledge
outData  output  Width  merged data
outChannel  output  ChanBits  source channel of outData
outValid  output  1  output valid
outReady  input  1  output ready
statTransfers  output  32  total accepted output transfers (see Optional Feature)

Behaviour:
- Reset (reset=0): inAck='0, outValid=0, outData='0, outChannel='0, all FIFOs empty, RR pointer=0, sync flops=0, statTransfers=0.
- Per channel: {inReq[c], inData[c]} pass through SyncCycles flops giving reqSync, dataSync.
- Per-channel FSM:
  - IDLE (ack=0): if reqSync=1 and FIFO not full -> write dataSync into FIFO, go to ACK, inAck=1 next cycle.
  - If reqSync=1 and FIFO full: stay IDLE with ack low; capture when space frees. Sender still holds data.
  - ACK (ack=1): when reqSync=0 -> IDLE, ack=0. No capture occurs in ACK.
- The full check uses start-of-cycle occupancy. A same-cycle read does not unblock a write.
- Simultaneous FIFO write and read on one channel is legal: occupancy is unchanged.
- Pointers carry an extra wrap bit. Empty = pointers equal. Full = pointers differ only in the MSB. They wrap modulo 2*Depth.
- Output register loads when !outValid || outReady.
  - Grant goes to the first non-empty channel at or after the RR pointer, wrapping modulo Channels.
  - The granted FIFO is popped, and outData/outChannel/outValid=1 are loaded.
  - The RR pointer moves to grant+1 mod Channels.
  - If there is no candidate, outValid falls (after an accepted beat) or stays 0.
- outData and outChannel are stable while outValid && !outReady.
- Latency: inReq rise to inAck rise = SyncCycles+1 clocks. Capture to outValid = 1 clock minimum when output is idle.
- Full throughput is one beat per clock across channels while outReady=1.
- Reset asserted mid-handshake: ack drops, and the captured beat is lost. The sender must restart the handshake after reset.

Optional Feature:
OC_ASYNC_REQ_ACK_MUX_STATS_EN:
- Defined: statTransfers is a 32-bit counter incremented on each outValid && outReady. It wraps 0xFFFFFFFF->0 and resets to 0.
- Undefined: statTransfers is tied to 32'd0 and no counter logic is built.

Decomposition:
- oclib_pkg holds the shared 4-phase FSM state typedef (IDLE, ACK) for reuse by other req/ack blocks.
- Sub-module oclib_async_req_ack_chan contains one channel:
  - synchronizer
  - FSM
  - Depth-entry FIFO with pop/data/empty interface
- The top instantiates Channels copies via generate, plus the RR arbiter and output register.

Test Plan:
- Single beat, defaults: ch2 sends 0xA5, outReady=1 -> inAck[2] rises SyncCycles+1 clocks after req; outValid pulses with outData=0xA5, outChannel=2; ack falls after req falls.
- Backpressure fill: outReady=0, ch0 sends 5 beats 0x01..0x05 -> first beat sits in the output register and 4 fill the FIFO. The sixth handshake stalls (ack low) until outReady=1. Data emerges in order 0x01..0x05, then the stalled beat.
- Fairness: all 4 channels hold a queued beat, outReady=1 -> grant order 0,1,2,3, then the pattern repeats from the channel after the last grant. No channel is skipped.
- Stall hold: outValid=1, outReady=0 for 10 clocks -> outData/outChannel unchanged. Beat accepted exactly once when outReady=1.
- Reset mid-handshake: reset=0 while inAck[1]=1 -> inAck, outValid, and FIFOs clear immediately. After release, a new ch1 handshake with 0x3C delivers 0x3C.
- Stats (macro defined): 100 accepted beats -> statTransfers=100. Reset -> 0. Macro undefined -> always 0.
